// File: rtl/soc_system_lt24_pkg.sv
// Shared constants for the LT24 control output PIO: register addresses and parameter defaults.
package soc_system_lt24_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_PULSE    = 3'd6;
  localparam logic [2:0] ADDR_PULSELEN = 3'd7;

  localparam logic [31:0] DEF_RESET_VALUE = 32'h0000_0001;
  localparam int          DEF_LEN_BITS    = 16;

endpackage

// File: rtl/lt24_pulse_timer.sv
// Timed pulse engine: holds the invert mask and a down-counter of remaining pulse cycles.
// state  | meaning
// IDLE   | cnt == 0, mask cleared, pins show plain data
// ACTIVE | cnt != 0, mask inverts the selected pins until cnt reaches 0
module lt24_pulse_timer #(
  parameter int WIDTH    = 8,
  parameter int LEN_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                pulse_we_i,
  input  logic [WIDTH-1:0]    mask_i,
  input  logic                len_we_i,
  input  logic [LEN_BITS-1:0] len_i,
  output logic [WIDTH-1:0]    mask_d_o,
  output logic [LEN_BITS-1:0] len_o,
  output logic                busy_o
);

  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [WIDTH-1:0]    mask_q, mask_d;

  // A new pulse always wins over abort and over the expiry of the current one.
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    if (pulse_we_i && (mask_i != '0)) begin
      cnt_d  = len_q;
      mask_d = mask_i;
    end else if (pulse_we_i) begin
      cnt_d  = '0;
      mask_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LEN_BITS'(1);
      if (cnt_q == LEN_BITS'(1)) mask_d = '0;
    end
  end

  // A zero length would never expire, so it is stored as one cycle.
  assign len_d = !len_we_i        ? len_q :
                 (len_i == '0)    ? LEN_BITS'(1) : len_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      mask_q <= '0;
      len_q  <= LEN_BITS'(1);
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      len_q  <= len_d;
    end
  end

  assign mask_d_o = mask_d;
  assign len_o    = len_q;
  assign busy_o   = (cnt_q != '0);

endmodule

// File: rtl/soc_system_lt24_ctrl_out.sv
// Avalon-MM output PIO for the LT24 control pins: data register with set/clear and a timed invert pulse.
module soc_system_lt24_ctrl_out
  import soc_system_lt24_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEF_RESET_VALUE),
  parameter int               LEN_BITS    = DEF_LEN_BITS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic                wr;
  logic [WIDTH-1:0]    wd;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    mask_d;
  logic [LEN_BITS-1:0] len;
  logic                busy;
  logic [31:0]         rd_d;
  logic                unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_d = wd;
        ADDR_OUTSET: data_d = data_q | wd;
        ADDR_OUTCLR: data_d = data_q & ~wd;
        default:     data_d = data_q;
      endcase
    end
  end

  lt24_pulse_timer #(
    .WIDTH    (WIDTH),
    .LEN_BITS (LEN_BITS)
  ) u_timer (
    .clk_i      (clk),
    .rst_n_i    (reset_n),
    .pulse_we_i (wr && (address == ADDR_PULSE)),
    .mask_i     (wd),
    .len_we_i   (wr && (address == ADDR_PULSELEN)),
    .len_i      (writedata[LEN_BITS-1:0]),
    .mask_d_o   (mask_d),
    .len_o      (len),
    .busy_o     (busy)
  );

  // Read mux follows the address every cycle, whether or not the slave is selected.
  always_comb begin
    case (address)
      ADDR_DATA:     rd_d = 32'(data_q);
      ADDR_PULSE:    rd_d = {31'b0, busy};
      ADDR_PULSELEN: rd_d = 32'(len);
      default:       rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      data_q   <= data_d;
      readdata <= rd_d;
      out_port <= data_d ^ mask_d;
    end
  end

endmodule
